// File: rtl/accel_bridge_pkg.sv
// Shared types and helpers for the accelerator-to-Avalon bridge.
package accel_bridge_pkg;

  // Size codes: size = log2(bytes in the access)
  localparam logic [2:0] SZ_8   = 3'd0;
  localparam logic [2:0] SZ_16  = 3'd1;
  localparam logic [2:0] SZ_32  = 3'd2;
  localparam logic [2:0] SZ_64  = 3'd3;
  localparam logic [2:0] SZ_128 = 3'd4;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_e;

  // Packed request layout is {size, data, addr} with addr at bit 0
  function automatic int fld_data_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int fld_size_lsb(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Largest size code a bus of be_w byte lanes can carry
  function automatic logic [2:0] max_size_code(input int be_w);
    case (be_w)
      1:       return SZ_8;
      2:       return SZ_16;
      4:       return SZ_32;
      8:       return SZ_64;
      default: return SZ_128;
    endcase
  endfunction

  function automatic logic [2:0] clamp_size(input logic [2:0] sz, input logic [2:0] max_sz);
    return (sz > max_sz) ? max_sz : sz;
  endfunction

endpackage

// File: rtl/accel_bridge_fifo.sv
// Show-ahead synchronous FIFO: o_dout always presents the oldest entry.
module accel_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // storage has no reset; entry validity is carried by the occupancy count
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // pointers and occupancy; reset flushes the queue
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/accel_avm_bridge.sv
// Buffered bridge from a LegUp packed memory port to an Avalon-MM master.
// Commands are queued, issued from the queue head, and read responses are
// realigned to the requested byte lane and returned in issue order.
module accel_avm_bridge
  import accel_bridge_pkg::*;
#(
  parameter int  ADDR_W      = 32,
  parameter int  DATA_W      = 64,
  parameter int  CMD_DEPTH   = 4,
  parameter int  MAX_PENDING = 4,
  localparam int BE_W        = DATA_W / 8,
  localparam int OFS_W       = $clog2(BE_W),
  localparam int REQ_W       = ADDR_W + DATA_W + 3,
  localparam int PCNT_W      = $clog2(MAX_PENDING) + 1
) (
  input  logic              csi_clockreset_clk,
  input  logic              csi_clockreset_reset,
  input  logic [REQ_W-1:0]  acc_writedata,
  input  logic              acc_write,
  input  logic              acc_read,
  output logic              acc_waitrequest,
  output logic [DATA_W-1:0] acc_readdata,
  output logic              acc_readdatavalid,
  output logic [ADDR_W-1:0] avm_ACCEL_address,
  output logic [DATA_W-1:0] avm_ACCEL_writedata,
  output logic [BE_W-1:0]   avm_ACCEL_byteenable,
  output logic              avm_ACCEL_write,
  output logic              avm_ACCEL_read,
  input  logic              avm_ACCEL_waitrequest,
  input  logic [DATA_W-1:0] avm_ACCEL_readdata,
  input  logic              avm_ACCEL_readdatavalid,
  output logic [PCNT_W-1:0] pending_cnt,
  output logic [2:0]        err_status
);

  localparam logic [2:0] MAX_SZ   = max_size_code(BE_W);
  localparam int         DATA_LSB = fld_data_lsb(ADDR_W);
  localparam int         SIZE_LSB = fld_size_lsb(ADDR_W, DATA_W);
  localparam int         CMD_W    = 1 + OFS_W + 3 + ADDR_W + DATA_W;
  localparam int         TAG_W    = OFS_W + 3;

  // low address bits that must be zero for an access of size sz
  function automatic logic [OFS_W-1:0] align_mask(input logic [2:0] sz);
    return OFS_W'((32'd1 << sz) - 32'd1);
  endfunction

  // byte lanes of a 2^sz-byte access at lane ofs; lanes past the bus are dropped
  function automatic logic [BE_W-1:0] be_of(input logic [2:0] sz, input logic [OFS_W-1:0] ofs);
    logic [2*BE_W-1:0] m;
    m = ((2*BE_W)'(1) << (32'd1 << sz)) - (2*BE_W)'(1);
    return BE_W'(m << ofs);
  endfunction

  // bit mask covering the low 2^sz bytes of the data bus
  function automatic logic [DATA_W-1:0] lane_mask(input logic [2:0] sz);
    logic [DATA_W:0] m;
    m = ((DATA_W+1)'(1) << ((32'd1 << sz) * 32'd8)) - (DATA_W+1)'(1);
    return DATA_W'(m);
  endfunction

  logic w_rst;
  assign w_rst = csi_clockreset_reset;

  // ---------------- request decode ----------------
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_data;
  logic [2:0]        w_req_size;
  logic [OFS_W-1:0]  w_req_ofs;
  kind_e             w_req_kind;
  logic              w_req_accept;
  logic              w_req_misal;
  logic              w_cmd_full;
  logic              w_cmd_empty;
  logic              w_cmd_pop;
  logic [CMD_W-1:0]  w_cmd_dout;

  assign w_req_addr   = acc_writedata[ADDR_W-1:0];
  assign w_req_data   = acc_writedata[DATA_LSB +: DATA_W];
  assign w_req_size   = clamp_size(acc_writedata[SIZE_LSB +: 3], MAX_SZ);
  assign w_req_ofs    = w_req_addr[OFS_W-1:0];
  // read+write together is resolved as a write
  assign w_req_kind   = acc_write ? KIND_WRITE : KIND_READ;
  assign w_req_misal  = |(w_req_ofs & align_mask(w_req_size));

  assign acc_waitrequest = w_cmd_full | w_rst;
  assign w_req_accept    = (acc_read | acc_write) & ~acc_waitrequest;

  accel_bridge_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (csi_clockreset_clk),
    .i_rst   (w_rst),
    .i_push  (w_req_accept),
    .i_din   ({w_req_kind, w_req_ofs, w_req_size, w_req_addr, w_req_data}),
    .i_pop   (w_cmd_pop),
    .o_dout  (w_cmd_dout),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty)
  );

  // ---------------- issue stage (queue head drives the bus) ----------------
  kind_e             w_hd_kind;
  logic [OFS_W-1:0]  w_hd_ofs;
  logic [2:0]        w_hd_size;
  logic [ADDR_W-1:0] w_hd_addr;
  logic [DATA_W-1:0] w_hd_data;
  logic              w_out_en;
  logic              w_pend_full;
  logic              w_pres_rd;
  logic              w_pres_wr;
  logic              w_rd_issue;

  assign w_hd_kind = kind_e'(w_cmd_dout[CMD_W-1]);
  assign w_hd_ofs  = w_cmd_dout[ADDR_W+DATA_W+3 +: OFS_W];
  assign w_hd_size = w_cmd_dout[ADDR_W+DATA_W +: 3];
  assign w_hd_addr = w_cmd_dout[DATA_W +: ADDR_W];
  assign w_hd_data = w_cmd_dout[DATA_W-1:0];

  // bus fields are zero whenever nothing is queued or reset is held
  assign w_out_en    = ~w_cmd_empty & ~w_rst;
  assign w_pend_full = (pending_cnt == PCNT_W'(MAX_PENDING));
  // a read at the head waits while the response window is full
  assign w_pres_rd   = w_out_en & (w_hd_kind == KIND_READ) & ~w_pend_full;
  assign w_pres_wr   = w_out_en & (w_hd_kind == KIND_WRITE);
  assign w_cmd_pop   = (w_pres_rd | w_pres_wr) & ~avm_ACCEL_waitrequest;
  assign w_rd_issue  = w_pres_rd & ~avm_ACCEL_waitrequest;

  assign avm_ACCEL_read       = w_pres_rd;
  assign avm_ACCEL_write      = w_pres_wr;
  assign avm_ACCEL_address    = w_out_en ? (w_hd_addr & ~ADDR_W'(BE_W - 1)) : '0;
  assign avm_ACCEL_writedata  = w_out_en ? (w_hd_data << {w_hd_ofs, 3'b000}) : '0;
  assign avm_ACCEL_byteenable = w_out_en ? be_of(w_hd_size, w_hd_ofs) : '0;

  // ---------------- read tags and response path ----------------
  logic [TAG_W-1:0]  w_tag_dout;
  logic              w_tag_full;
  logic              w_tag_empty;
  logic              w_tag_pop;
  logic [OFS_W-1:0]  w_tag_ofs;
  logic [2:0]        w_tag_size;
  logic [DATA_W-1:0] w_rdata_aligned;

  accel_bridge_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .i_clk   (csi_clockreset_clk),
    .i_rst   (w_rst),
    .i_push  (w_rd_issue),
    .i_din   ({w_hd_ofs, w_hd_size}),
    .i_pop   (w_tag_pop),
    .o_dout  (w_tag_dout),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  assign w_tag_ofs       = w_tag_dout[3 +: OFS_W];
  assign w_tag_size      = w_tag_dout[2:0];
  // data with no matching tag belongs to an abandoned read and is dropped
  assign w_tag_pop       = avm_ACCEL_readdatavalid & ~w_tag_empty;
  assign w_rdata_aligned = (avm_ACCEL_readdata >> {w_tag_ofs, 3'b000}) & lane_mask(w_tag_size);

  logic [PCNT_W-1:0] r_pend_cnt;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        r_err;

  // outstanding-read counter; simultaneous issue and return cancel out
  always_ff @(posedge csi_clockreset_clk) begin
    if (w_rst) begin
      r_pend_cnt <= '0;
    end else begin
      case ({w_rd_issue, w_tag_pop})
        2'b10:   r_pend_cnt <= r_pend_cnt + PCNT_W'(1);
        2'b01:   r_pend_cnt <= r_pend_cnt - PCNT_W'(1);
        default: r_pend_cnt <= r_pend_cnt;
      endcase
    end
  end

  // registered, realigned read response
  always_ff @(posedge csi_clockreset_clk) begin
    if (w_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_tag_pop;
      if (w_tag_pop) r_rdata <= w_rdata_aligned;
    end
  end

  // sticky error flags, cleared only by reset
  always_ff @(posedge csi_clockreset_clk) begin
    if (w_rst) begin
      r_err <= '0;
    end else begin
      r_err[0] <= r_err[0] | (w_req_accept & w_req_misal);
      r_err[1] <= r_err[1] | (w_req_accept & acc_read & acc_write);
      r_err[2] <= r_err[2] | (avm_ACCEL_readdatavalid & w_tag_empty);
    end
  end

  assign pending_cnt       = r_pend_cnt;
  assign acc_readdatavalid = r_rvalid;
  assign acc_readdata      = r_rdata;
  assign err_status        = r_err;

  // tag queue can never overflow: issue is gated by the pending count
  logic w_unused;
  assign w_unused = w_tag_full;

endmodule
